router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the 1x3 router input port: drives the router's pkt_valid/data bus and honours its busy.
//  Buffers a payload from a local byte stream, then sends header, payload and a trailing parity byte.
//  Used as the synthesizable stimulus/loopback source in the router test system.
// PARAMETERS
//  GAP_CYCLES  2   minimum idle cycles (pkt_valid=0, no transfer) after a parity byte before the next header
//  CNT_W       16  width of the sent-packet counter
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rstn       in   1      asynchronous active-low reset
//  start      in   1      request to send a packet; sampled in IDLE only
//  dest       in   2      destination address, 0..2; 3 is illegal
//  len        in   6      payload length in bytes, 1..63; 0 is illegal
//  pl_data    in   8      payload byte
//  pl_valid   in   1      pl_data valid
//  pl_ready   out  1      block accepts pl_data this cycle
//  busy       in   1      router busy; holds the bus
//  pkt_valid  out  1      router pkt_valid
//  data_out   out  8      router data input
//  tx_active  out  1      high in every state except IDLE
//  done       out  1      1-cycle pulse: parity byte transferred
//  cfg_err    out  1      1-cycle pulse: start rejected (dest==3 or len==0)
//  pkt_cnt    out  CNT_W  packets completed, wraps to 0 after all-ones
// BEHAVIOUR
//  - Reset, any time including mid-packet: state IDLE. All outputs 0: pkt_valid, data_out, pl_ready, tx_active, done, cfg_err, pkt_cnt.
//    The 64x8 payload buffer is not reset. A partial packet is abandoned.
//  - FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP. All outputs registered.
//  - IDLE, start=1:
//    - Illegal dest/len: cfg_err=1 for the next cycle; stay IDLE.
//    - Otherwise latch hdr={len,dest}, set parity=hdr, wcnt=0, go to LOAD.
//    - start in any other state is ignored.
//  - LOAD: pl_ready=1.
//    - Each cycle with pl_valid&&pl_ready: buf[wcnt]<=pl_data, parity^=pl_data, wcnt++.
//    - pl_valid gaps are allowed. On the handshake with wcnt==len-1: pl_ready<=0, go to HEADER.
//  - Bus transfer rule: a bus byte is consumed on a posedge where busy==0.
//    While busy==1, pkt_valid and data_out hold exactly. A byte is never duplicated or dropped.
//  - HEADER: pkt_valid=1, data_out=hdr. On transfer, rcnt=0, go to PAYLOAD.
//  - PAYLOAD: pkt_valid=1, data_out=buf[rcnt], back-to-back. On transfer of byte rcnt==len-1, go to PARITY.
//  - PARITY: pkt_valid=0, data_out=parity (XOR of header and all payload bytes).
//    On transfer: done=1 for one cycle, pkt_cnt++, go to GAP.
//  - GAP: pkt_valid=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
//    Header-to-header spacing is at least GAP_CYCLES+len+3 cycles.
//  - First header byte appears the cycle after the last LOAD handshake.
//    With busy=0, header to parity takes len+2 consecutive cycles.
// CONFIGURATION
//  - ROUTER_TX_ERR_INJ_EN defined:
//    - Adds input err_inj (1 bit), sampled with start.
//    - If err_inj=1, the byte sent in PARITY is parity^8'h01. Internal state is otherwise unchanged.
//  - ROUTER_TX_ERR_INJ_EN undefined: no err_inj port; parity is always correct.
// TESTING
//  1. dest=1, len=3, payload 11,22,33, busy=0
//     -> bus 0D,11,22,33 with pkt_valid=1, then 0D with pkt_valid=0; done pulse; pkt_cnt=1.
//  2. Same packet with busy=1 for 2 cycles while 22 is on the bus
//     -> 22 held 3 cycles; exactly 5 bytes transferred; parity 0D.
//  3. start with dest=3, then with len=0
//     -> cfg_err pulse each time; pl_ready=0, pkt_valid=0, pkt_cnt unchanged.
//  4. Two back-to-back len=63 packets, pl_valid toggling every cycle
//     -> both packets correct; at least 2 idle cycles between the first parity and the second header; pkt_cnt=2.
//  5. rstn low mid-PAYLOAD
//     -> pkt_valid=0 and data_out=0 with no clock edge; a following len=1, dest=0 packet sends 04,AA,AE.
//  6. ROUTER_TX_ERR_INJ_EN, err_inj=1, test 1 stimulus -> parity byte 0C; other bytes unchanged.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// Router input-port bus: pkt_valid/data toward the router, busy back from it.
// master = packet source (router_pkt_tx), slave = router input port.
interface router_pkt_tx_if;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy;

    modport master (output pkt_valid, output data_out, input busy);
    modport slave  (input pkt_valid, input data_out, output busy);
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a payload, then sends header, payload and parity.
// Optional ROUTER_TX_ERR_INJ_EN adds err_inj, which flips bit 0 of the transmitted parity byte.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       dest,
    input  logic [5:0]       len,
`ifdef ROUTER_TX_ERR_INJ_EN
    input  logic             err_inj,
`endif
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    router_pkt_tx_if.master  bus,
    output logic             tx_active,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    logic [7:0]       hdr;
    logic [7:0]       parity;
    logic [5:0]       len_q;
    logic [5:0]       wcnt;
    logic [5:0]       rcnt;
    logic [GAP_W-1:0] gcnt;
    logic             inj_q;
    logic             inj_in;
    logic             pkt_valid_q;
    logic [7:0]       data_q;
    logic [7:0]       pl_buf [0:63];
    logic             load_hs;

`ifdef ROUTER_TX_ERR_INJ_EN
    assign inj_in = err_inj;
`else
    assign inj_in = 1'b0;
`endif

    assign load_hs       = (state == LOAD) && pl_valid && pl_ready;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out  = data_q;

    // NOTE: the payload RAM has no reset; its contents are only read after being written for this packet.
    always_ff @(posedge clk) begin
        if (load_hs) begin
            pl_buf[wcnt] <= pl_data;
        end
    end

    // NOTE: all state and outputs use <= so every branch sees the values from before this edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            hdr         <= '0;
            parity      <= '0;
            len_q       <= '0;
            wcnt        <= '0;
            rcnt        <= '0;
            gcnt        <= '0;
            inj_q       <= 1'b0;
            pl_ready    <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_q      <= '0;
            tx_active   <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dest == 2'd3 || len == 6'd0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            hdr       <= {len, dest};
                            parity    <= {len, dest};
                            len_q     <= len;
                            wcnt      <= '0;
                            inj_q     <= inj_in;
                            pl_ready  <= 1'b1;
                            tx_active <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        parity <= parity ^ pl_data;
                        wcnt   <= wcnt + 6'd1;
                        if (wcnt == len_q - 6'd1) begin
                            pl_ready    <= 1'b0;
                            pkt_valid_q <= 1'b1;
                            data_q      <= hdr;
                            state       <= HEADER;
                        end
                    end
                end
                // Bus bytes advance only on edges with busy low; otherwise outputs hold.
                HEADER: begin
                    if (!bus.busy) begin
                        rcnt   <= '0;
                        data_q <= pl_buf[6'd0];
                        state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!bus.busy) begin
                        if (rcnt == len_q - 6'd1) begin
                            pkt_valid_q <= 1'b0;
                            data_q      <= parity ^ {7'b0, inj_q};
                            state       <= PARITY;
                        end else begin
                            rcnt   <= rcnt + 6'd1;
                            data_q <= pl_buf[rcnt + 6'd1];
                        end
                    end
                end
                PARITY: begin
                    if (!bus.busy) begin
                        done    <= 1'b1;
                        pkt_cnt <= pkt_cnt + 1'b1;
                        data_q  <= '0;
                        gcnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            tx_active <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gcnt == GAP_W'(GAP_CYCLES - 1)) begin
                        tx_active <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed and randomized packets against a byte-list model.
// Define ROUTER_TX_ERR_INJ_EN for both bench and RTL to exercise the parity error injection.
module tb_router_pkt_tx;

    localparam int GAP_CYCLES = 2;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [1:0]  dest;
    logic [5:0]  len;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        tx_active;
    logic        done;
    logic        cfg_err;
    logic [15:0] pkt_cnt;
`ifdef ROUTER_TX_ERR_INJ_EN
    logic        err_inj;
`endif

    router_pkt_tx_if bus_if ();

    router_pkt_tx #(.GAP_CYCLES(GAP_CYCLES), .CNT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dest      (dest),
        .len       (len),
`ifdef ROUTER_TX_ERR_INJ_EN
        .err_inj   (err_inj),
`endif
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .bus       (bus_if),
        .tx_active (tx_active),
        .done      (done),
        .cfg_err   (cfg_err),
        .pkt_cnt   (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_cnt  = 0;
    logic [7:0] pl [0:63];
    logic [7:0] last_hdr;
    logic [7:0] last_par;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive illegal start requests outside IDLE; the DUT must ignore them.
    task automatic start_noise();
        start = 1'($urandom_range(0, 1));
        dest  = 2'd3;
        len   = 6'd0;
    endtask

    // Sends one packet with payload pl[0..l-1] and checks every bus cycle against
    // the expected byte list {hdr, payload..., parity}. abort_at >= 0 returns
    // early when that byte index is on the bus (used for the reset test).
    task automatic send_pkt(input logic [1:0] d, input logic [5:0] l, input logic inj,
                            input int busy_mode, input int plv_mode, input int abort_at);
        logic [7:0] exp_b [0:65];
        logic       exp_v [0:65];
        logic [7:0] par;
        int         n;
        int         idx;
        int         cyc;
        int         hold;
        logic       b;

        n        = int'(l);
        par      = {l, d};
        exp_b[0] = {l, d};
        exp_v[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_b[i+1] = pl[i];
            exp_v[i+1] = 1'b1;
            par        = par ^ pl[i];
        end
        exp_b[n+1] = par ^ {7'b0, inj};
        exp_v[n+1] = 1'b0;

        start = 1'b1;
        dest  = d;
        len   = l;
`ifdef ROUTER_TX_ERR_INJ_EN
        err_inj = inj;
`endif
        tick();
        check("load_tx_active", tx_active, 1);
        check("load_pl_ready", pl_ready, 1);

        for (int i = 0; i < n; i++) begin
            if (plv_mode == 1 || (plv_mode == 2 && $urandom_range(0, 2) == 0)) begin
                pl_valid = 1'b0;
                pl_data  = 8'($urandom);
                start_noise();
                tick();
            end
            pl_valid = 1'b1;
            pl_data  = pl[i];
            start_noise();
            tick();
        end
        pl_valid = 1'b0;
        check("hdr_pl_ready_low", pl_ready, 0);

        idx  = 0;
        cyc  = 0;
        hold = 0;
        while (idx < n + 2 && cyc < 8 * (n + 2) + 16) begin
            if (idx == abort_at) return;
            check($sformatf("bus_valid[%0d]", idx), bus_if.pkt_valid, exp_v[idx]);
            check($sformatf("bus_data[%0d]", idx), bus_if.data_out, exp_b[idx]);
            check("done_low", done, 0);
            check("cfg_err_ignored", cfg_err, 0);
            if (idx == 0)     last_hdr = bus_if.data_out;
            if (idx == n + 1) last_par = bus_if.data_out;
            case (busy_mode)
                1:       b = (idx == 2 && hold < 2);
                2:       b = ($urandom_range(0, 3) == 0);
                default: b = 1'b0;
            endcase
            if (b) hold++;
            bus_if.busy = b;
            start_noise();
            tick();
            cyc++;
            if (!b) idx++;
        end
        bus_if.busy = 1'b0;
        start       = 1'b0;
        check("xfer_count", idx, n + 2);
        check("done_pulse", done, 1);
        exp_cnt++;
        check("pkt_cnt", pkt_cnt, 32'(16'(exp_cnt)));

        for (int g = 0; g < GAP_CYCLES; g++) begin
            check("gap_valid", bus_if.pkt_valid, 0);
            check("gap_data", bus_if.data_out, 0);
            check("gap_tx_active", tx_active, 1);
            check("gap_done", done, (g == 0) ? 1 : 0);
            tick();
        end
        check("idle_after_gap", tx_active, 0);
    endtask

    task automatic fill_payload(input int n);
        for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
    endtask

    initial begin
        logic [1:0] rd;
        logic [5:0] rl;
        logic       ri;

        rstn        = 1'b1;
        start       = 1'b0;
        dest        = '0;
        len         = '0;
        pl_data     = '0;
        pl_valid    = 1'b0;
        bus_if.busy = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
        err_inj     = 1'b0;
`endif
        #2 rstn = 1'b0;
        #1;
        check("rst_pkt_valid", bus_if.pkt_valid, 0);
        check("rst_data_out", bus_if.data_out, 0);
        check("rst_pl_ready", pl_ready, 0);
        check("rst_tx_active", tx_active, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        tick();

        // Basic packet: dest=1, len=3, payload 11,22,33.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, 0, 0, -1);
        check("t1_hdr", last_hdr, 8'h0D);
        check("t1_par", last_par, 8'h0D);
        check("t1_cnt", pkt_cnt, 1);

        // Same packet with busy held for two cycles while 22 is on the bus.
        send_pkt(2'd1, 6'd3, 1'b0, 1, 0, -1);
        check("t2_par", last_par, 8'h0D);

        // Illegal requests.
        start = 1'b1; dest = 2'd3; len = 6'd5;
        tick();
        check("t3a_cfg_err", cfg_err, 1);
        check("t3a_pl_ready", pl_ready, 0);
        check("t3a_pkt_valid", bus_if.pkt_valid, 0);
        check("t3a_tx_active", tx_active, 0);
        start = 1'b0;
        tick();
        check("t3a_cfg_err_pulse", cfg_err, 0);
        start = 1'b1; dest = 2'd1; len = 6'd0;
        tick();
        check("t3b_cfg_err", cfg_err, 1);
        check("t3b_pl_ready", pl_ready, 0);
        start = 1'b0;
        tick();
        check("t3b_cfg_err_pulse", cfg_err, 0);
        check("t3_pkt_cnt", pkt_cnt, 32'(16'(exp_cnt)));

        // Two back-to-back maximum-length packets with pl_valid toggling.
        fill_payload(63);
        send_pkt(2'd2, 6'd63, 1'b0, 0, 1, -1);
        fill_payload(63);
        send_pkt(2'd0, 6'd63, 1'b0, 0, 1, -1);
        check("t4_cnt", pkt_cnt, 4);

        // Randomized packets with random busy and payload gaps.
        for (int k = 0; k < 6; k++) begin
            rd = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 63));
`ifdef ROUTER_TX_ERR_INJ_EN
            ri = 1'($urandom_range(0, 1));
`else
            ri = 1'b0;
`endif
            fill_payload(int'(rl));
            send_pkt(rd, rl, ri, 2, 2, -1);
        end

        // Reset in the middle of the payload, then a minimal packet.
        fill_payload(10);
        send_pkt(2'd2, 6'd10, 1'b0, 0, 0, 5);
        start       = 1'b0;
        bus_if.busy = 1'b0;
        #1 rstn = 1'b0;
        #1;
        check("t5_rst_valid", bus_if.pkt_valid, 0);
        check("t5_rst_data", bus_if.data_out, 0);
        check("t5_rst_tx_active", tx_active, 0);
        check("t5_rst_pkt_cnt", pkt_cnt, 0);
        exp_cnt = 0;
        @(negedge clk) rstn = 1'b1;
        tick();
        pl[0] = 8'hAA;
        send_pkt(2'd0, 6'd1, 1'b0, 0, 0, -1);
        check("t5_hdr", last_hdr, 8'h04);
        check("t5_par", last_par, 8'hAE);

`ifdef ROUTER_TX_ERR_INJ_EN
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b1, 0, 0, -1);
        check("t6_hdr", last_hdr, 8'h0D);
        check("t6_par", last_par, 8'h0C);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
